// File: rtl/ecc_point_ctrl.sv
// rtl/ecc_point_ctrl.sv - affine ECC point add/double sequencer driving a GF arithmetic unit
// One GF micro-op in flight at a time; intermediates live in a small local register file.
module ecc_point_ctrl #(
  parameter int SIZE    = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            start,
  input  logic            mode,
  input  logic [SIZE-1:0] x1,
  input  logic [SIZE-1:0] y1,
  input  logic [SIZE-1:0] x2,
  input  logic [SIZE-1:0] y2,
  input  logic [SIZE-1:0] a_coef,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [SIZE-1:0] x3,
  output logic [SIZE-1:0] y3,
  output logic [SIZE-1:0] gf_in_0,
  output logic [SIZE-1:0] gf_in_1,
  output logic [1:0]      gf_op,
  output logic            gf_start,
  input  logic [SIZE-1:0] gf_result,
  input  logic            gf_done_add,
  input  logic            gf_done_sub,
  input  logic            gf_done_mult,
  input  logic            gf_done_div
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MULT = 2'd2;
  localparam logic [1:0] OP_DIV  = 2'd3;

  localparam logic [3:0] R_X1 = 4'd0;
  localparam logic [3:0] R_Y1 = 4'd1;
  localparam logic [3:0] R_X2 = 4'd2;
  localparam logic [3:0] R_Y2 = 4'd3;
  localparam logic [3:0] R_A  = 4'd4;
  localparam logic [3:0] R_L  = 4'd5;
  localparam logic [3:0] R_T0 = 4'd6;
  localparam logic [3:0] R_T1 = 4'd7;
  localparam logic [3:0] R_T2 = 4'd8;
  localparam logic [3:0] R_T3 = 4'd9;
  localparam logic [3:0] R_X3 = 4'd10;
  localparam logic [3:0] R_Y3 = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_FIN
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] s0;
    logic [3:0] s1;
    logic [3:0] dst;
  } uop_t;

  // Double shares the add tail (steps 7-12 = add steps 4-9); x2 is loaded with x1 for doubles.
  function automatic uop_t rom(input logic dbl, input logic [3:0] idx);
    uop_t       u;
    logic [3:0] k;
    u = {OP_ADD, R_X1, R_X1, R_T0};
    k = idx;
    if (dbl && idx < 4'd6) begin
      case (idx)
        4'd0:    u = {OP_MULT, R_X1, R_X1, R_T0};
        4'd1:    u = {OP_ADD,  R_T0, R_T0, R_T1};
        4'd2:    u = {OP_ADD,  R_T1, R_T0, R_T0};
        4'd3:    u = {OP_ADD,  R_T0, R_A,  R_T0};
        4'd4:    u = {OP_ADD,  R_Y1, R_Y1, R_T1};
        default: u = {OP_DIV,  R_T0, R_T1, R_L};
      endcase
    end else begin
      if (dbl) k = idx - 4'd3;
      case (k)
        4'd0:    u = {OP_SUB,  R_Y2, R_Y1, R_T0};
        4'd1:    u = {OP_SUB,  R_X2, R_X1, R_T1};
        4'd2:    u = {OP_DIV,  R_T0, R_T1, R_L};
        4'd3:    u = {OP_MULT, R_L,  R_L,  R_T2};
        4'd4:    u = {OP_SUB,  R_T2, R_X1, R_T2};
        4'd5:    u = {OP_SUB,  R_T2, R_X2, R_X3};
        4'd6:    u = {OP_SUB,  R_X1, R_X3, R_T3};
        4'd7:    u = {OP_MULT, R_L,  R_T3, R_T3};
        default: u = {OP_SUB,  R_T3, R_Y1, R_Y3};
      endcase
    end
    return u;
  endfunction

  state_t          state;
  logic [3:0]      step;
  logic [TW-1:0]   tmo_cnt;
  logic            mode_q;
  logic [SIZE-1:0] rf    [12];
  logic [SIZE-1:0] rf_nx [12];

  uop_t       cur_uop;
  uop_t       nxt_uop;
  logic [3:0] nxt_idx;
  logic [3:0] last_step;
  logic       op_done;
  logic       wr_en;
  logic       degenerate;

  assign last_step  = mode_q ? 4'd11 : 4'd8;
  assign nxt_idx    = (state == S_WAIT) ? step + 4'd1 : step;
  assign cur_uop    = rom(mode_q, step);
  assign nxt_uop    = rom(mode_q, nxt_idx);
  assign wr_en      = (state == S_WAIT) && op_done;
  assign degenerate = mode_q ? (rf[R_Y1] == '0) : (rf[R_X1] == rf[R_X2]);

  always_comb begin
    op_done = 1'b0;
    case (gf_op)
      OP_ADD:  op_done = gf_done_add;
      OP_SUB:  op_done = gf_done_sub;
      OP_MULT: op_done = gf_done_mult;
      default: op_done = gf_done_div;
    endcase
  end

  // Next register file image; the next issue reads from it so a result written this
  // cycle is forwarded straight to the operands of the following micro-op.
  always_comb begin
    for (int i = 0; i < 12; i++) rf_nx[i] = rf[i];
    if (state == S_IDLE && start) begin
      rf_nx[R_X1] = x1;
      rf_nx[R_Y1] = y1;
      rf_nx[R_X2] = mode ? x1 : x2;
      rf_nx[R_Y2] = y2;
      rf_nx[R_A]  = a_coef;
    end
    if (wr_en) rf_nx[cur_uop.dst] = gf_result;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      step     <= '0;
      tmo_cnt  <= '0;
      mode_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      x3       <= '0;
      y3       <= '0;
      gf_in_0  <= '0;
      gf_in_1  <= '0;
      gf_op    <= '0;
      gf_start <= 1'b0;
      for (int i = 0; i < 12; i++) rf[i] <= '0;
    end else begin
      for (int i = 0; i < 12; i++) rf[i] <= rf_nx[i];
      gf_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode;
            step   <= '0;
            error  <= 1'b0;
            busy   <= 1'b1;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (degenerate) begin
            error <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FIN;
          end else begin
            gf_op    <= nxt_uop.op;
            gf_in_0  <= rf_nx[nxt_uop.s0];
            gf_in_1  <= rf_nx[nxt_uop.s1];
            gf_start <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (op_done) begin
            if (step == last_step) begin
              x3    <= rf_nx[R_X3];
              y3    <= rf_nx[R_Y3];
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FIN;
            end else begin
              step     <= step + 4'd1;
              gf_op    <= nxt_uop.op;
              gf_in_0  <= rf_nx[nxt_uop.s0];
              gf_in_1  <= rf_nx[nxt_uop.s1];
              gf_start <= 1'b1;
              state    <= S_ISSUE;
            end
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            error <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FIN;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
